// File: rtl/rmii_tx_framer.sv
// RMII 100 Mb/s transmit framer: preamble/SFD, payload, zero pad, FCS and IFG on a dibit-per-clock
// interface, plus the 2-bit reflected CRC-32 engine it drives.

module crc_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        crc_en,
  input  logic [1:0]  data_in,
  output logic [31:0] crc_out
);
  logic [31:0] r_lfsr;
  logic [31:0] w_seed;
  logic [31:0] w_step;

  function automatic logic [31:0] crc_step2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 2; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ 32'hEDB88320;
      else             x = x >> 1;
    end
    return x;
  endfunction

  // Init substitutes the all-ones seed, so a dibit enabled during init is folded into a fresh CRC.
  assign w_seed  = reset_n ? r_lfsr : 32'hFFFF_FFFF;
  assign w_step  = crc_step2(w_seed, data_in);
  assign crc_out = ~w_step;

  always_ff @(posedge clk) begin
    r_lfsr <= crc_en ? w_step : w_seed;
  end
endmodule

module rmii_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_BYTES      = 60,
  parameter int IFG_CYCLES     = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [1:0] txd,
  output logic       tx_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG} state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES * 4 + 3);
  localparam logic [7:0]  PRE_SFD  = 8'(PREAMBLE_BYTES * 4 + 2);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_BYTES);
  // The single IDLE cycle before PRE completes the gap, so IFG itself lasts one cycle less.
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 2);

  state_t      r_state;
  logic [7:0]  r_idx;
  logic [7:0]  r_sh;
  logic        r_last;
  logic [10:0] r_cnt;
  logic [31:0] r_fcs;
  logic [15:0] r_ifg;

  logic        w_pad_more;
  logic        w_take;
  logic        w_fcs_latch;
  logic        w_fcs_go;
  logic        w_crc_init_n;
  logic        w_crc_en;
  logic [1:0]  w_crc_d;
  logic [31:0] w_crc_out;

  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == 11'h7FF) ? c : c + 11'd1;
  endfunction

  assign w_pad_more   = r_cnt < MIN_CNT;
  assign s_tready     = (r_state == S_PRE  && r_idx == PRE_LAST) ||
                        (r_state == S_DATA && r_idx == 8'd3 && !r_last) ||
                        (r_state == S_DROP);
  assign tx_busy      = r_state != S_IDLE;
  assign w_take       = s_tvalid && s_tready && (r_state == S_PRE || r_state == S_DATA);
  assign w_crc_init_n = !(r_state == S_IDLE || r_state == S_PRE);
  assign w_fcs_latch  = (r_idx == 8'd2) && !w_pad_more &&
                        ((r_state == S_DATA && r_last) || r_state == S_PAD);
  assign w_fcs_go     = (r_idx == 8'd3) && !w_pad_more &&
                        ((r_state == S_DATA && r_last) || r_state == S_PAD);

  // The CRC sees each DATA/PAD dibit as it is loaded into the txd flop.
  always_comb begin
    w_crc_en = 1'b0;
    w_crc_d  = 2'b00;
    case (r_state)
      S_PRE: begin
        if (r_idx == PRE_LAST && s_tvalid) begin
          w_crc_en = 1'b1;
          w_crc_d  = s_tdata[1:0];
        end
      end
      S_DATA: begin
        if (r_idx != 8'd3) begin
          w_crc_en = 1'b1;
          w_crc_d  = r_sh[3:2];
        end else if (!r_last) begin
          w_crc_en = s_tvalid;
          w_crc_d  = s_tdata[1:0];
        end else begin
          w_crc_en = w_pad_more;
        end
      end
      S_PAD:   w_crc_en = (r_idx != 8'd3) || w_pad_more;
      default: w_crc_en = 1'b0;
    endcase
  end

  crc_gen u_crc (
    .clk    (clk),
    .reset_n(w_crc_init_n),
    .crc_en (w_crc_en),
    .data_in(w_crc_d),
    .crc_out(w_crc_out)
  );

  always_ff @(posedge clk) begin
    if (w_take)                  r_sh <= s_tdata;
    else if (r_state == S_DATA)  r_sh <= r_sh >> 2;
    if (w_fcs_latch)                     r_fcs <= w_crc_out;
    else if (w_fcs_go || r_state == S_FCS) r_fcs <= r_fcs >> 2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 8'd0;
      r_last      <= 1'b0;
      r_cnt       <= 11'd0;
      r_ifg       <= 16'd0;
      txd         <= 2'b00;
      tx_en       <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_tvalid) begin
            r_state <= S_PRE;
            r_idx   <= 8'd0;
            txd     <= 2'b01;
            tx_en   <= 1'b1;
          end
        end
        S_PRE: begin
          if (r_idx != PRE_LAST) begin
            r_idx <= r_idx + 8'd1;
            txd   <= (r_idx == PRE_SFD) ? 2'b11 : 2'b01;
          end else if (s_tvalid) begin
            r_state <= S_DATA;
            r_idx   <= 8'd0;
            r_last  <= s_tlast;
            r_cnt   <= 11'd1;
            txd     <= s_tdata[1:0];
          end else begin
            r_state     <= S_DROP;
            tx_en       <= 1'b0;
            txd         <= 2'b00;
            tx_underrun <= 1'b1;
          end
        end
        S_DATA, S_PAD: begin
          if (r_idx != 8'd3) begin
            r_idx <= r_idx + 8'd1;
            txd   <= (r_state == S_DATA) ? r_sh[3:2] : 2'b00;
          end else if (r_state == S_DATA && !r_last) begin
            if (s_tvalid) begin
              r_idx  <= 8'd0;
              r_last <= s_tlast;
              r_cnt  <= sat_inc(r_cnt);
              txd    <= s_tdata[1:0];
            end else begin
              r_state     <= S_DROP;
              tx_en       <= 1'b0;
              txd         <= 2'b00;
              tx_underrun <= 1'b1;
            end
          end else if (w_pad_more) begin
            r_state <= S_PAD;
            r_idx   <= 8'd0;
            r_cnt   <= sat_inc(r_cnt);
            txd     <= 2'b00;
          end else begin
            r_state <= S_FCS;
            r_idx   <= 8'd0;
            txd     <= r_fcs[1:0];
          end
        end
        S_FCS: begin
          if (r_idx != 8'd15) begin
            r_idx   <= r_idx + 8'd1;
            txd     <= r_fcs[1:0];
            tx_done <= (r_idx == 8'd14);
          end else begin
            r_state <= S_IFG;
            r_ifg   <= 16'd0;
            tx_en   <= 1'b0;
            txd     <= 2'b00;
          end
        end
        S_DROP: begin
          if (s_tvalid && s_tlast) begin
            r_state <= S_IFG;
            r_ifg   <= 16'd0;
          end
        end
        S_IFG: begin
          if (r_ifg >= IFG_LAST) r_state <= S_IDLE;
          else                   r_ifg   <= r_ifg + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rmii_tx_framer.sv
// Bench for rmii_tx_framer: a frame-level model predicts every dibit on txd/tx_en, the gap and the
// tx_done/tx_underrun pulses; directed frames plus 200 random frames exercise it.

module tb_rmii_tx_framer;
  localparam int PRE_B = 7;
  localparam int MIN_B = 60;
  localparam int IFG_C = 48;

  typedef logic [7:0] bq_t[$];
  typedef struct { int len; int done; int lit; bit exact; } meta_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [1:0] txd;
  logic       tx_en, tx_busy, tx_done, tx_underrun;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q[$];
  meta_t      meta_q[$];
  meta_t      cur;
  logic [1:0] rx_q[$];
  bit         chk_en = 1'b0;
  bit         in_frame = 1'b0;
  bit         have_prev = 1'b0;
  bit         prev_ur = 1'b0;
  int         hi = 0, lowrun = 0, done_seen = 0, ur_seen = 0, exp_ur = 0;
  logic [1:0] e;

  rmii_tx_framer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .txd        (txd),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int got, input int lo);
    tests++;
    if (got < lo) begin
      fails++;
      $display("FAIL %s: got %0d required >= %0d", nm, got, lo);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[i][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic [31:0] residue(input logic [1:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      for (int j = 0; j < 2; j++) begin
        if (c[0] ^ d[i][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(b[i][2*k +: 2]);
    end
  endtask

  task automatic queue_frame(input bq_t data, input int ur, input int lit, input bit exact);
    meta_t       m;
    bq_t         tx;
    logic [31:0] fcs;
    for (int i = 0; i < PRE_B * 4 + 3; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    if (ur >= 0) begin
      for (int i = 0; i < ur; i++) tx.push_back(data[i]);
      m.done = 0;
      exp_ur++;
    end else begin
      tx = data;
      while (tx.size() < MIN_B) tx.push_back(8'h00);
      fcs = crc32(tx);
      for (int k = 0; k < 4; k++) tx.push_back(fcs[8*k +: 8]);
      m.done = 1;
    end
    push_bytes(tx);
    m.len   = 4 * (PRE_B + 1) + 4 * tx.size();
    m.lit   = lit;
    m.exact = exact;
    meta_q.push_back(m);
  endtask

  task automatic wait_ready();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!s_tready && g < 2000);
    if (!s_tready) begin
      $display("FAIL s_tready_timeout: got 0 required 1 within 2000 cycles");
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t data, input int ur, input int lit, input bit exact);
    queue_frame(data, ur, lit, exact);
    foreach (data[i]) begin
      if (i == ur) begin
        s_tvalid = 1'b0;
        wait_ready();
      end
      s_tdata  = data[i];
      s_tlast  = (i == data.size() - 1);
      s_tvalid = 1'b1;
      wait_ready();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    prev_ur  = (ur >= 0);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((meta_q.size() != 0 || in_frame || tx_busy) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_idle", 32'(tx_busy), 0);
  endtask

  always @(negedge clk) begin
    if (!chk_en || !reset_n) begin
      in_frame  = 1'b0;
      have_prev = 1'b0;
      lowrun    = 0;
    end else begin
      if (tx_en && !in_frame) begin
        if (meta_q.size() == 0) begin
          chk("unexpected_frame", 32'(tx_en), 0);
        end else begin
          cur       = meta_q.pop_front();
          in_frame  = 1'b1;
          hi        = 0;
          done_seen = 0;
          rx_q.delete();
          if (have_prev) begin
            if (cur.exact) chk("ifg_gap", 32'(lowrun), IFG_C);
            else           chk_ge("ifg_gap_min", lowrun, IFG_C);
          end
        end
      end
      if (tx_en && in_frame) begin
        hi++;
        if (hi <= cur.len && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txd", 32'(txd), 32'(e));
        end
        if (hi > 4 * (PRE_B + 1)) rx_q.push_back(txd);
        if (tx_done) begin
          done_seen++;
          chk("tx_done_pos", 32'(hi), 32'(cur.len));
        end
      end else if (!tx_en) begin
        if (in_frame) begin
          chk("tx_en_len", 32'(hi), 32'(cur.len));
          if (cur.lit != 0) chk("tx_en_len_lit", 32'(hi), 32'(cur.lit));
          chk("tx_done_cnt", 32'(done_seen), 32'(cur.done));
          if (cur.done != 0) chk("fcs_residue", ~residue(rx_q), 32'h2144DF1C);
          for (int i = hi; i < cur.len; i++) void'(exp_q.pop_front());
          in_frame  = 1'b0;
          have_prev = 1'b1;
          lowrun    = 0;
        end
        lowrun++;
        chk("txd_idle", 32'(txd), 0);
        chk("tx_done_idle", 32'(tx_done), 0);
      end
      if (tx_underrun) ur_seen++;
    end
  end

  initial begin
    bq_t q;
    bq_t pin;
    int  n, ur, dly;

    pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", crc32(pin), 32'hCBF43926);

    repeat (3) @(negedge clk);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_txd", 32'(txd), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_tx_underrun", 32'(tx_underrun), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);

    // 60 counting bytes, then a single 0xAB byte padded to minimum length
    q.delete();
    for (int i = 0; i < 60; i++) q.push_back(8'(i));
    send_frame(q, -1, 288, 1'b0);
    q.delete();
    q.push_back(8'hAB);
    send_frame(q, -1, 288, 1'b1);

    // two 64-byte frames with s_tvalid held high
    for (int f = 0; f < 2; f++) begin
      q.delete();
      for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
      send_frame(q, -1, 0, 1'b1);
    end

    // underrun at byte 10 of a 20-byte frame, then a normal frame after the drain
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    send_frame(q, 10, 0, 1'b1);
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(8'($urandom));
    send_frame(q, -1, 0, 1'b0);
    wait_drain();
    chk("underrun_once", 32'(ur_seen), 1);

    // asynchronous reset in the middle of DATA
    chk_en   = 1'b0;
    s_tdata  = 8'h5A;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_frame_tx_en", 32'(tx_en), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx_en", 32'(tx_en), 0);
    chk("async_rst_txd", 32'(txd), 0);
    chk("async_rst_busy", 32'(tx_busy), 0);
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(tx_busy), 0);
    chk("post_rst_s_tready", 32'(s_tready), 0);
    chk("post_rst_tx_en", 32'(tx_en), 0);
    chk_en = 1'b1;
    @(negedge clk);
    q.delete();
    for (int i = 0; i < 45; i++) q.push_back(8'($urandom));
    send_frame(q, -1, 288, 1'b0);

    // 200 random frames, some with a mid-frame underrun
    for (int f = 0; f < 200; f++) begin
      n  = $urandom_range(1, 70);
      ur = ($urandom_range(0, 7) == 0 && n >= 2) ? int'($urandom_range(1, n - 1)) : -1;
      dly = ($urandom_range(0, 3) == 0) ? 60 : 0;
      if (dly != 0) begin
        repeat (dly) @(posedge clk);
        #1;
      end
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      send_frame(q, ur, 0, (dly == 0) && !prev_ur);
    end
    wait_drain();
    chk("underrun_total", 32'(ur_seen), 32'(exp_ur));
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("meta_q_empty", 32'(meta_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
